// File: rtl/crc16_frame_feeder_if.sv
// rtl/crc16_frame_feeder_if.sv - upstream byte stream, CRC engine and frame result signals
interface crc16_frame_feeder_if;
  // upstream byte stream
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        abort;
  // CRC16-MODBUS engine side
  logic        crc_init;
  logic [7:0]  crc_data;
  logic        crc_valid;
  logic        crc_busy;
  logic [15:0] crc_value;
  // frame result
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_crc;
  logic [7:0]  frame_len;

  // feeder view
  modport slave (
    input  s_data, s_valid, s_last, abort, crc_busy, crc_value,
    output s_ready, crc_init, crc_data, crc_valid,
           frame_done, frame_ok, frame_crc, frame_len
  );

  // environment view: byte source, CRC engine and result sink
  modport master (
    output s_data, s_valid, s_last, abort, crc_busy, crc_value,
    input  s_ready, crc_init, crc_data, crc_valid,
           frame_done, frame_ok, frame_crc, frame_len
  );
endinterface

// File: rtl/crc16_frame_feeder.sv
// rtl/crc16_frame_feeder.sv - feeds buffered frame bytes to a CRC16-MODBUS engine and checks the residue
module crc16_frame_feeder (
  input  logic                 clk,
  input  logic                 rst,
  crc16_frame_feeder_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, INIT, ISSUE, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [8:0]  mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic [7:0]  len_q, len_d;
  logic        last_q, last_d;
  logic        wait_first_q;
  logic        frame_done_q, frame_ok_q;
  logic [15:0] frame_crc_q;
  logic [7:0]  frame_len_q;

  logic        fifo_empty, fifo_full;
  logic        push, pop, capture, init_pulse;
  logic [8:0]  head;

  assign fifo_empty = (count_q == 3'd0);
  assign fifo_full  = (count_q == 3'd4);
  assign head       = mem_q[rd_ptr_q];
  // ready depends only on registered occupancy, never on s_valid
  assign push       = bus.s_valid && !fifo_full && !bus.abort;

  // next-state and engine strobes; abort overrides every other decision
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    last_d     = last_q;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        len_d = 8'd0;
        if (!fifo_empty) state_d = INIT;
      end
      INIT: state_d = ISSUE;
      ISSUE: begin
        if (!fifo_empty && !bus.crc_busy) begin
          pop     = 1'b1;
          len_d   = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
          last_d  = head[8];
          state_d = WAIT;
        end
      end
      WAIT: begin
        // busy is registered in the engine, so it is not yet valid on the first WAIT cycle
        if (!wait_first_q && !bus.crc_busy) begin
          if (last_q) begin
            capture = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      pop     = 1'b0;
      capture = 1'b0;
    end
    init_pulse = bus.abort || (state_q == INIT);
  end

  // FSM state and per-frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= 8'd0;
      last_q       <= 1'b0;
      wait_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      last_q       <= last_d;
      wait_first_q <= pop;
    end
  end

  // FIFO pointers and occupancy; abort empties the buffer
  always_ff @(posedge clk) begin
    if (rst || bus.abort) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  // FIFO storage of {last, byte}
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.s_last, bus.s_data};
  end

  // frame result registers, held until the next completed frame
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_crc_q  <= 16'h0000;
      frame_len_q  <= 8'd0;
    end else begin
      frame_done_q <= capture;
      if (capture) begin
        frame_ok_q  <= (bus.crc_value == 16'h0000) && (len_q >= 8'd3);
        frame_crc_q <= bus.crc_value;
        frame_len_q <= len_q;
      end
    end
  end

  assign bus.s_ready    = !fifo_full;
  assign bus.crc_init   = init_pulse;
  assign bus.crc_valid  = pop;
  assign bus.crc_data   = pop ? head[7:0] : 8'h00;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_ok   = frame_ok_q;
  assign bus.frame_crc  = frame_crc_q;
  assign bus.frame_len  = frame_len_q;

endmodule

// File: tb/tb_crc16_frame_feeder.sv
// tb/tb_crc16_frame_feeder.sv - self-checking bench for crc16_frame_feeder
module tb_crc16_frame_feeder;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic        ok;
    logic [15:0] crc;
    logic [7:0]  len;
    int          cyc;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  crc16_frame_feeder_if bus();

  crc16_frame_feeder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  function automatic logic [15:0] model_crc(input byte_q_t b);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) c = crc_step(c, b[i]);
    return c;
  endfunction

  // ideal CRC engine: result ready at once, busy for 8 cycles after each byte
  logic [15:0] eng_crc;
  int          eng_cnt;
  always @(posedge clk) begin
    if (rst) begin
      eng_crc <= 16'hFFFF;
      eng_cnt <= 0;
    end else begin
      if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
      if (bus.crc_init) eng_crc <= 16'hFFFF;
      else if (bus.crc_valid) begin
        eng_crc <= crc_step(eng_crc, bus.crc_data);
        eng_cnt <= 8;
      end
    end
  end
  assign bus.crc_busy  = (eng_cnt != 0);
  assign bus.crc_value = eng_crc;

  // monitor, sampled mid-cycle
  int          cyc = 0;
  logic [7:0]  got_q [$];
  int          vcyc_q [$];
  int          icyc_q [$];
  res_t        res_q [$];
  int          n_init = 0;
  int          n_overlap = 0;
  int          n_stall = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.crc_valid) begin
        got_q.push_back(bus.crc_data);
        vcyc_q.push_back(cyc);
      end
      if (bus.crc_init) begin
        n_init = n_init + 1;
        icyc_q.push_back(cyc);
      end
      if (bus.crc_init && bus.crc_valid) n_overlap = n_overlap + 1;
      if (bus.frame_done) res_q.push_back('{ok: bus.frame_ok, crc: bus.frame_crc, len: bus.frame_len, cyc: cyc});
      if (!bus.s_ready) n_stall = n_stall + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input string tag, input byte_q_t b);
    int n;
    for (int i = 0; i < b.size(); i++) begin
      bus.s_data  = b[i];
      bus.s_last  = (i == b.size() - 1);
      bus.s_valid = 1'b1;
      n = 0;
      while (!bus.s_ready && n < 3000) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 3000) check({tag, "_ready_timeout"}, 0, 1);
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (res_q.size() < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, (res_q.size() >= target), 1);
  endtask

  logic        last_ok;
  logic [15:0] last_crc;
  logic [7:0]  last_len;

  // checks bytes at the engine, strobe spacing and the frame result for one frame
  task automatic check_frame(input string tag, input byte_q_t b, input int gs, input int ri);
    int          bad, sp;
    logic [15:0] ec;
    logic [7:0]  elen;
    ec   = model_crc(b);
    elen = (b.size() > 255) ? 8'hFF : 8'(b.size());
    bad = 0;
    sp  = 0;
    for (int i = 0; i < b.size() && gs + i < got_q.size(); i++) begin
      if (got_q[gs + i] !== b[i]) bad++;
      if (i > 0 && vcyc_q[gs + i] - vcyc_q[gs + i - 1] != 10) sp++;
    end
    check({tag, "_byte_order"}, bad, 0);
    check({tag, "_spacing"}, sp, 0);
    if (res_q.size() > ri) begin
      check({tag, "_ok"},  res_q[ri].ok,  ((ec == 16'h0000) && b.size() >= 3));
      check({tag, "_crc"}, res_q[ri].crc, ec);
      check({tag, "_len"}, res_q[ri].len, elen);
      if (got_q.size() >= gs + b.size())
        check({tag, "_done_lat"}, res_q[ri].cyc - vcyc_q[gs + b.size() - 1], 10);
    end
    last_ok  = (ec == 16'h0000) && b.size() >= 3;
    last_crc = ec;
    last_len = elen;
  endtask

  task automatic run_frame(input string tag, input byte_q_t b);
    int gs, rs, is;
    gs = got_q.size();
    rs = res_q.size();
    is = n_init;
    push_frame(tag, b);
    wait_done(tag, rs + 1, 20 * b.size() + 300);
    check({tag, "_inits"}, n_init - is, 1);
    check({tag, "_nbytes"}, got_q.size() - gs, b.size());
    check_frame(tag, b, gs, rs);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t     fa, fb, f2, fr;
    logic [63:0] pat;
    logic [15:0] c;
    int          gs, rs, is, st, len;

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    bus.abort   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_ready",    bus.s_ready,    1);
    check("rst_crc_init",   bus.crc_init,   0);
    check("rst_crc_valid",  bus.crc_valid,  0);
    check("rst_crc_data",   bus.crc_data,   0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_frame_ok",   bus.frame_ok,   0);
    check("rst_frame_crc",  bus.frame_crc,  0);
    check("rst_frame_len",  bus.frame_len,  0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // known-good MODBUS request
    pat = 64'h0103_0000_0001_840A;
    for (int i = 0; i < 8; i++) fa.push_back(pat[63 - 8*i -: 8]);
    run_frame("good8", fa);

    // corrupted final CRC byte
    f2 = fa;
    f2[7] = 8'h0B;
    run_frame("bad8", f2);
    check("bad8_crc_nonzero", (res_q.size() > 0 && res_q[res_q.size() - 1].crc != 16'h0000), 1);

    // six-byte back-to-back burst must stall upstream
    fr.delete();
    for (int i = 0; i < 6; i++) fr.push_back(8'($urandom_range(0, 255)));
    st = n_stall;
    run_frame("burst6", fr);
    check("burst6_stalled", (n_stall > st), 1);

    // two frames pushed back to back
    fa.delete();
    fb.delete();
    for (int i = 0; i < 5; i++) fa.push_back(8'($urandom_range(0, 255)));
    c = model_crc(fa);
    fa.push_back(c[7:0]);
    fa.push_back(c[15:8]);
    for (int i = 0; i < 4; i++) fb.push_back(8'($urandom_range(0, 255)));
    gs = got_q.size();
    rs = res_q.size();
    is = n_init;
    push_frame("b2b_a", fa);
    push_frame("b2b_b", fb);
    wait_done("b2b", rs + 2, 1000);
    check("b2b_inits", n_init - is, 2);
    if (icyc_q.size() > is + 1 && res_q.size() > rs)
      check("b2b_init_after_done", (icyc_q[is + 1] > res_q[rs].cyc), 1);
    check_frame("b2b_a", fa, gs, rs);
    check_frame("b2b_b", fb, gs + fa.size(), rs + 1);

    // abort while waiting on byte 3, with a stray byte offered in the same cycle
    fr.delete();
    for (int i = 0; i < 5; i++) fr.push_back(8'(8'h11 * (i + 1)));
    gs = got_q.size();
    rs = res_q.size();
    push_frame("abort", fr);
    len = 0;
    while (got_q.size() < gs + 3 && len < 500) begin
      @(negedge clk);
      len++;
    end
    @(posedge clk); #1;
    is = n_init;
    bus.abort   = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hAA;
    bus.s_last  = 1'b1;
    @(posedge clk); #1;
    bus.abort   = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    check("abort_init_pulse", n_init - is, 1);
    repeat (60) @(posedge clk);
    #1;
    check("abort_no_done",    res_q.size() - rs, 0);
    check("abort_no_bytes",   got_q.size() - gs, 3);
    check("abort_s_ready",    bus.s_ready, 1);
    check("abort_held_ok",    bus.frame_ok,  last_ok);
    check("abort_held_crc",   bus.frame_crc, last_crc);
    check("abort_held_len",   bus.frame_len, last_len);
    fa.delete();
    for (int i = 0; i < 8; i++) fa.push_back(pat[63 - 8*i -: 8]);
    run_frame("post_abort", fa);
    check("post_abort_ok", bus.frame_ok, 1);

    // single zero byte
    fr.delete();
    fr.push_back(8'h00);
    run_frame("single", fr);

    // random frames, about half with a correct CRC appended
    for (int k = 0; k < 5; k++) begin
      fr.delete();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) fr.push_back(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 1) == 1) begin
        c = model_crc(fr);
        fr.push_back(c[7:0]);
        fr.push_back(c[15:8]);
      end
      run_frame($sformatf("rand%0d", k), fr);
    end

    // long frame saturates the length counter
    fr.delete();
    for (int i = 0; i < 298; i++) fr.push_back(8'($urandom_range(0, 255)));
    c = model_crc(fr);
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    run_frame("long300", fr);

    check("init_valid_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
